// File: rtl/simd_pkg.sv
// Shared opcode encoding, default geometry and saturation helper for simd_exec_pipe.
// Saturation is used only when SIMD_EXEC_SAT_EN is defined.
package simd_pkg;

    localparam int DEF_LANES = 4;
    localparam int DEF_WIDTH = 16;
    localparam int DEF_FRAC  = DEF_WIDTH - 1;
    localparam int DEF_GUARD = 8;

    // Widest intermediate the saturate helper can take; callers sign-extend into it.
    localparam int SAT_MAXW = 128;

    typedef enum logic [2:0] {
        OP_VADD = 3'b000,
        OP_VSUB = 3'b001,
        OP_VMUL = 3'b010,
        OP_VMAC = 3'b011,
        OP_VCLR = 3'b100,
        OP_VRED = 3'b101,
        OP_RSV6 = 3'b110,
        OP_RSV7 = 3'b111
    } op_e;

    // Clamp a sign-extended value to the signed range of a w-bit number.
    function automatic logic signed [SAT_MAXW-1:0] saturate(
        input logic signed [SAT_MAXW-1:0] v,
        input int                         w
    );
        logic signed [SAT_MAXW-1:0] hi;
        logic signed [SAT_MAXW-1:0] lo;
        hi = (SAT_MAXW'(1) <<< (w - 1)) - SAT_MAXW'(1);
        lo = -hi - SAT_MAXW'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/simd_lane.sv
// One SIMD lane: E2 operand arithmetic register, E3 result logic and the lane accumulator.
// Results and accumulator saturate when SIMD_EXEC_SAT_EN is defined, otherwise wrap.
module simd_lane
    import simd_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = WIDTH - 1,
    parameter int GUARD = DEF_GUARD
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            load_e2,
    input  op_e                             e1_op,
    input  logic signed [WIDTH-1:0]         e1_a,
    input  logic signed [WIDTH-1:0]         e1_b,
    input  logic                            commit,
    input  op_e                             e2_op,
    output logic signed [WIDTH-1:0]         result,
    output logic signed [2*WIDTH+GUARD-1:0] acc
);

    localparam int PW   = 2 * WIDTH;
    localparam int ACCW = 2 * WIDTH + GUARD;
    localparam int XW   = ACCW + 1;

    function automatic logic signed [WIDTH-1:0] fit_w(input logic signed [XW-1:0] v);
`ifdef SIMD_EXEC_SAT_EN
        return WIDTH'(saturate(SAT_MAXW'(v), WIDTH));
`else
        return WIDTH'(v);
`endif
    endfunction

    function automatic logic signed [ACCW-1:0] fit_acc(input logic signed [XW-1:0] v);
`ifdef SIMD_EXEC_SAT_EN
        return ACCW'(saturate(SAT_MAXW'(v), ACCW));
`else
        return ACCW'(v);
`endif
    endfunction

    logic signed [PW-1:0]   e2_val;
    logic signed [XW-1:0]   mac_sum;
    logic signed [ACCW-1:0] acc_next;

    // Sums and the full-precision product share one E2 register; only one is live per op.
    always_ff @(posedge clk) begin
        if (load_e2) begin
            case (e1_op)
                OP_VADD:          e2_val <= PW'(e1_a) + PW'(e1_b);
                OP_VSUB:          e2_val <= PW'(e1_a) - PW'(e1_b);
                OP_VMUL, OP_VMAC: e2_val <= PW'(e1_a) * PW'(e1_b);
                default:          e2_val <= '0;
            endcase
        end
    end

    // NOTE: every output of this block gets a default first so no latch is inferred.
    always_comb begin
        mac_sum  = XW'(acc) + XW'(e2_val);
        acc_next = acc;
        result   = '0;
        case (e2_op)
            OP_VADD, OP_VSUB: result = fit_w(XW'(e2_val));
            OP_VMUL:          result = fit_w(XW'(e2_val) >>> FRAC);
            OP_VMAC: begin
                acc_next = fit_acc(mac_sum);
                result   = fit_w(XW'(acc_next) >>> FRAC);
            end
            OP_VCLR:          acc_next = '0;
            default:          ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc <= '0;
        end else if (commit) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/simd_exec_pipe.sv
// Three-stage SIMD execute pipe (E1 latch, E2 multiply/add, E3 accumulate/result) with
// flush, backpressure and cross-lane reduction. Define SIMD_EXEC_SAT_EN for saturating results.
module simd_exec_pipe
    import simd_pkg::*;
#(
    parameter int LANES = DEF_LANES,
    parameter int WIDTH = DEF_WIDTH,
    parameter int FRAC  = WIDTH - 1,
    parameter int GUARD = DEF_GUARD
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2:0]               op,
    input  logic [LANES*WIDTH-1:0]   a,
    input  logic [LANES*WIDTH-1:0]   b,
    input  logic                     flush,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [LANES*WIDTH-1:0]   out_data,
    output logic                     busy
);

    localparam int ACCW = 2 * WIDTH + GUARD;
    localparam int SUMW = ACCW + $clog2(LANES) + 1;

    function automatic logic signed [WIDTH-1:0] fit_red(input logic signed [SUMW-1:0] v);
`ifdef SIMD_EXEC_SAT_EN
        return WIDTH'(saturate(SAT_MAXW'(v), WIDTH));
`else
        return WIDTH'(v);
`endif
    endfunction

    logic                    e1_valid, e2_valid, e3_valid;
    op_e                     e1_op, e2_op;
    logic [LANES*WIDTH-1:0]  e1_a, e1_b;
    logic                    stall, accept, load_e2, commit;

    logic signed [WIDTH-1:0] lane_res [LANES];
    logic signed [ACCW-1:0]  lane_acc [LANES];
    logic signed [SUMW-1:0]  red_sum;
    logic signed [WIDTH-1:0] red_res;
    logic [LANES*WIDTH-1:0]  next_data;

    // A held result freezes the whole pipe; flush kills E1/E2 and the commit leaving E2.
    assign stall     = e3_valid && !out_ready;
    assign in_ready  = !stall;
    assign accept    = in_valid && in_ready && !flush;
    assign load_e2   = !stall && e1_valid;
    assign commit    = !stall && e2_valid && !flush;
    assign out_valid = e3_valid;
    assign busy      = e1_valid || e2_valid || e3_valid;

    always_ff @(posedge clk) begin
        if (reset) begin
            e1_valid <= 1'b0;
            e2_valid <= 1'b0;
            e3_valid <= 1'b0;
        end else if (flush) begin
            e1_valid <= 1'b0;
            e2_valid <= 1'b0;
            if (!stall) e3_valid <= 1'b0;
        end else if (!stall) begin
            e1_valid <= accept;
            e2_valid <= e1_valid;
            e3_valid <= e2_valid;
        end
    end

    // NOTE: datapath registers carry no reset; the stage valid bits qualify their contents.
    always_ff @(posedge clk) begin
        if (accept) begin
            e1_op <= op_e'(op);
            e1_a  <= a;
            e1_b  <= b;
        end
        if (load_e2) e2_op <= e1_op;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        simd_lane #(
            .WIDTH (WIDTH),
            .FRAC  (FRAC),
            .GUARD (GUARD)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .load_e2 (load_e2),
            .e1_op   (e1_op),
            .e1_a    (e1_a[i*WIDTH +: WIDTH]),
            .e1_b    (e1_b[i*WIDTH +: WIDTH]),
            .commit  (commit),
            .e2_op   (e2_op),
            .result  (lane_res[i]),
            .acc     (lane_acc[i])
        );
    end

    // VRED reads the committed accumulators; lanes already return 0 for it.
    always_comb begin
        red_sum = '0;
        for (int i = 0; i < LANES; i++) red_sum = red_sum + SUMW'(lane_acc[i]);
        red_res   = fit_red(red_sum >>> FRAC);
        next_data = '0;
        for (int i = 0; i < LANES; i++) next_data[i*WIDTH +: WIDTH] = lane_res[i];
        if (e2_op == OP_VRED) next_data[WIDTH-1:0] = red_res;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out_data <= '0;
        end else if (commit) begin
            out_data <= next_data;
        end
    end

endmodule

// File: tb/tb_simd_exec_pipe.sv
// Self-checking bench for simd_exec_pipe: an op-level reference model compared every cycle,
// plus directed vectors with literal expected results (honours SIMD_EXEC_SAT_EN).
module tb_simd_exec_pipe;

    localparam logic [2:0] VADD = 3'd0, VSUB = 3'd1, VMUL = 3'd2, VMAC = 3'd3,
                           VCLR = 3'd4, VRED = 3'd5;

`ifdef SIMD_EXEC_SAT_EN
    localparam logic [63:0] EXP_VADD   = 64'h0003_0000_2345_7FFF;
    localparam logic [63:0] EXP_VMUL_N = {4{16'h7FFF}};
    localparam logic [63:0] EXP_MAC4   = {4{16'h7FFF}};
    localparam logic [63:0] EXP_RED4   = 64'h0000_0000_0000_7FFF;
`else
    localparam logic [63:0] EXP_VADD   = 64'h0003_0000_2345_9000;
    localparam logic [63:0] EXP_VMUL_N = {4{16'h8000}};
    localparam logic [63:0] EXP_MAC4   = {4{16'h8000}};
    localparam logic [63:0] EXP_RED4   = 64'h0000_0000_0000_0000;
`endif

    logic        clk = 1'b0;
    logic        reset, in_valid, in_ready, flush, out_valid, out_ready, busy;
    logic [2:0]  op;
    logic [63:0] a, b, out_data;

    int checks   = 0;
    int failures = 0;

    simd_exec_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        bit          v;
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] res;
    } slot_t;

    slot_t  m1, m2, m3;
    longint macc [4];
    bit     started = 1'b0;
    bit     stall_m;

    function automatic logic [15:0] fit16(input longint v);
`ifdef SIMD_EXEC_SAT_EN
        if (v > 32767)  return 16'h7FFF;
        if (v < -32768) return 16'h8000;
`endif
        return 16'(v);
    endfunction

    function automatic longint fitacc(input longint v);
        logic [39:0] t;
`ifdef SIMD_EXEC_SAT_EN
        if (v > 64'sd549755813887)  return 64'sd549755813887;
        if (v < -64'sd549755813888) return -64'sd549755813888;
`endif
        t = v[39:0];
        return longint'($signed(t));
    endfunction

    // Result of one op in Q-format arithmetic; updates the model accumulators.
    function automatic logic [63:0] model_exec(input logic [2:0] o, input logic [63:0] va,
                                               input logic [63:0] vb);
        logic [63:0] r;
        longint      s;
        r = '0;
        for (int i = 0; i < 4; i++) begin
            longint x, y;
            x = longint'($signed(va[i*16 +: 16]));
            y = longint'($signed(vb[i*16 +: 16]));
            case (o)
                VADD: r[i*16 +: 16] = fit16(x + y);
                VSUB: r[i*16 +: 16] = fit16(x - y);
                VMUL: r[i*16 +: 16] = fit16((x * y) >>> 15);
                VMAC: begin
                    macc[i] = fitacc(macc[i] + x * y);
                    r[i*16 +: 16] = fit16(macc[i] >>> 15);
                end
                VCLR: macc[i] = 0;
                default: ;
            endcase
        end
        if (o == VRED) begin
            s = 0;
            for (int i = 0; i < 4; i++) s += macc[i];
            r[15:0] = fit16(s >>> 15);
        end
        return r;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m1.v = 1'b0;
            m2.v = 1'b0;
            m3.v = 1'b0;
            foreach (macc[i]) macc[i] = 0;
            started = 1'b1;
        end else begin
            stall_m = m3.v && !out_ready;
            if (flush) begin
                m1.v = 1'b0;
                m2.v = 1'b0;
                if (!stall_m) m3.v = 1'b0;
            end else if (!stall_m) begin
                m3 = m2;
                if (m2.v) m3.res = model_exec(m2.op, m2.a, m2.b);
                m2 = m1;
                m1 = '{in_valid, op, a, b, 64'h0};
            end
        end
    end

    always @(negedge clk) begin
        if (started) begin
            check("model_out_valid", {63'h0, out_valid}, {63'h0, m3.v});
            check("model_busy", {63'h0, busy}, {63'h0, (m1.v | m2.v | m3.v)});
            check("model_in_ready", {63'h0, in_ready}, {63'h0, !(m3.v && !out_ready)});
            if (m3.v) check("model_out_data", out_data, m3.res);
        end
    end

    // Every delivered result, in order, for the literal checks.
    logic [63:0] got [$];
    always @(negedge clk) begin
        if (started && out_valid && out_ready) got.push_back(out_data);
    end

    // ---------------- stimulus helpers (called at posedge + 2) ----------------
    task automatic drive_op(input logic [2:0] o, input logic [63:0] va, input logic [63:0] vb);
        int n;
        bit ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        op = o;
        a  = va;
        b  = vb;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready;
            n++;
            @(posedge clk);
            #2;
        end
        in_valid = 1'b0;
        check("accept", {63'h0, ok}, 64'h1);
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 100);
        check("drain", {63'h0, busy}, 64'h0);
        @(posedge clk);
        #2;
    endtask

    task automatic check_q(input string name, input logic [63:0] exp);
        if (got.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL %s: got no result expected %h", name, exp);
        end else begin
            check(name, got.pop_front(), exp);
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int lat;
        int sent;
        reset = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0;
        flush = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        check("rst_out_valid", {63'h0, out_valid}, 64'h0);
        check("rst_busy", {63'h0, busy}, 64'h0);
        check("rst_in_ready", {63'h0, in_ready}, 64'h1);
        check("rst_out_data", out_data, 64'h0);
        @(posedge clk);
        #2;

        // VADD with latency measurement, then VSUB
        drive_op(VADD, 64'h0001_FFFF_1234_7000, 64'h0002_0001_1111_2000);
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!out_valid && lat < 10);
        check("vadd_latency", 64'(lat), 64'd3);
        wait_drain();
        check_q("vadd", EXP_VADD);
        drive_op(VSUB, 64'h0001_FFFF_1234_7000, 64'h0002_0001_1111_2000);
        wait_drain();
        check_q("vsub", 64'hFFFF_FFFE_0123_5000);

        // VMUL, back-to-back
        drive_op(VMUL, {4{16'h4000}}, {4{16'h4000}});
        drive_op(VMUL, {4{16'h8000}}, {4{16'h8000}});
        wait_drain();
        check_q("vmul_half", {4{16'h2000}});
        check_q("vmul_neg1", EXP_VMUL_N);

        // VCLR, four VMAC and VRED back-to-back
        drive_op(VCLR, 64'h0, 64'h0);
        repeat (4) drive_op(VMAC, {4{16'h4000}}, {4{16'h4000}});
        drive_op(VRED, 64'h0, 64'h0);
        wait_drain();
        check_q("vclr", 64'h0);
        check_q("vmac1", {4{16'h2000}});
        check_q("vmac2", {4{16'h4000}});
        check_q("vmac3", {4{16'h6000}});
        check_q("vmac4", EXP_MAC4);
        check_q("vred4", EXP_RED4);

        // Backpressure: out_ready low for 5 cycles during a 6-op stream
        got.delete();
        sent = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = !(cyc >= 4 && cyc <= 8);
            in_valid  = (sent < 6);
            op = VADD;
            a  = {4{16'(sent)}};
            b  = {4{16'h0100}};
            @(negedge clk);
            if (cyc >= 4 && cyc <= 8) check("bp_in_ready", {63'h0, in_ready}, 64'h0);
            if (in_valid && in_ready) sent++;
            @(posedge clk);
            #2;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("bp_sent", 64'(sent), 64'd6);
        for (int i = 0; i < 6; i++) begin
            logic [15:0] e;
            e = 16'(i) + 16'h0100;
            check_q("bp_order", {4{e}});
        end

        // Flush with VMAC in E1 and E2; the E3 VMAC completes
        got.delete();
        drive_op(VCLR, 64'h0, 64'h0);
        drive_op(VMAC, {4{16'h2000}}, {4{16'h2000}});
        wait_drain();
        repeat (3) drive_op(VMAC, {4{16'h2000}}, {4{16'h2000}});
        flush = 1'b1;
        in_valid = 1'b1;
        op = VMAC;
        @(posedge clk);
        #2;
        flush = 1'b0;
        in_valid = 1'b0;
        wait_drain();
        drive_op(VRED, 64'h0, 64'h0);
        wait_drain();
        check_q("fl_vclr", 64'h0);
        check_q("fl_vmac_pre", {4{16'h0800}});
        check_q("fl_vmac_e3", {4{16'h1000}});
        check_q("fl_vred", 64'h0000_0000_0000_4000);
        check("fl_extra", 64'(got.size()), 64'd0);

        // Reset with three ops in flight
        repeat (3) drive_op(VMAC, {4{16'h2000}}, {4{16'h2000}});
        reset = 1'b1;
        @(posedge clk);
        #2;
        reset = 1'b0;
        @(negedge clk);
        check("rip_out_valid", {63'h0, out_valid}, 64'h0);
        check("rip_busy", {63'h0, busy}, 64'h0);
        check("rip_in_ready", {63'h0, in_ready}, 64'h1);
        @(posedge clk);
        #2;
        got.delete();
        drive_op(VRED, 64'h0, 64'h0);
        wait_drain();
        check_q("rip_vred", 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/simd_exec_pipe.md
SIMD_EXEC_PIPE -- requirements
Module: simd_exec_pipe

Interface
REQ-001 SHALL have parameter LANES, default 4, number of parallel lanes.
REQ-002 SHALL have parameter WIDTH, default 16, signed sample width per lane.
REQ-003 SHALL have parameter FRAC, default WIDTH-1, fractional bits of the Q format.
REQ-004 SHALL have parameter GUARD, default 8, accumulator guard bits; ACCW = 2*WIDTH+GUARD.
REQ-005 SHALL have ports: clk  in  1  sole clock; reset  in  1  synchronous, active-high reset.
REQ-006 SHALL have ports: in_valid  in  1; in_ready  out  1; op  in  3  opcode; a, b  in  LANES*WIDTH  packed lane operands, lane 0 in the LSBs.
REQ-007 SHALL have ports: flush  in  1  kill in-flight ops; out_valid  out  1; out_ready  in  1; out_data  out  LANES*WIDTH; busy  out  1  any stage valid.

Function
REQ-008 SHALL run three stages (E1 operand latch, E2 multiply/add, E3 accumulate/result), each with a valid bit; latency from accept to out_valid is 3 cycles.
REQ-009 SHALL accept an input when in_valid && in_ready; in_ready = !(out_valid && !out_ready).
REQ-010 SHALL freeze all stages and keep out_data stable while out_valid && !out_ready; no op is lost or duplicated.
REQ-011 SHALL decode op: 000 VADD a+b; 001 VSUB a-b; 010 VMUL (a*b)>>>FRAC; 011 VMAC acc+=a*b, output acc>>>FRAC; 100 VCLR acc=0, output 0; 101 VRED lane 0 = (sum of all lane acc)>>>FRAC, other lanes 0; 110/111 output 0, no acc change.
REQ-012 SHALL form products at full 2*WIDTH signed precision and hold one ACCW-bit accumulator per lane; accumulator wraps at ACCW.
REQ-013 SHALL commit an accumulator update only on the advance from E2 into E3; back-to-back VMAC/VCLR/VRED see each prior committed result with no stall.
REQ-014 SHALL truncate results to WIDTH by taking the low WIDTH bits (two's-complement wrap) unless REQ-021 applies.
REQ-015 SHALL, on flush, clear E1 and E2 valid bits in the same edge, discard any input accepted in that cycle, and suppress the accumulator commit of the op leaving E2; the op already in E3 still completes.
REQ-016 SHALL give flush priority over stall: flush while frozen still clears E1/E2.
REQ-017 SHALL assert busy whenever any stage valid bit is set.

Reset
REQ-018 SHALL, on reset at a clock edge, clear all stage valid bits, all accumulators, and out_data to 0; in-flight ops are discarded.
REQ-019 SHALL, after reset, output out_valid=0, busy=0, in_ready=1.
REQ-020 SHALL give reset priority over flush, stall and input.

Configuration
REQ-021 SHALL, with SIMD_EXEC_SAT_EN defined, saturate each lane result to [-2^(WIDTH-1), 2^(WIDTH-1)-1] and the accumulator to its ACCW signed range; without it, all results and the accumulator wrap.

Structure
REQ-022 SHALL take the opcode enum (VADD..VRED), default LANES/WIDTH/FRAC/GUARD and the saturate function from shared package simd_pkg.
REQ-023 SHALL instantiate sub-module simd_lane once per lane for the per-lane arithmetic and accumulator; the E1/E2/E3 control and VRED reduction stay in simd_exec_pipe.

Verification
REQ-024 SHALL cover VADD: lane 0x7000 + 0x2000 -> 0x9000 without SAT_EN, 0x7FFF with SAT_EN; out_valid exactly 3 cycles after accept.
REQ-025 SHALL cover VMUL: 0x4000*0x4000 on all lanes -> 0x2000 on all lanes; 0x8000*0x8000 -> 0x8000 wrapped, 0x7FFF with SAT_EN.
REQ-026 SHALL cover 4 back-to-back VMAC of 0x4000*0x4000 after VCLR -> 0x2000, 0x4000, 0x6000, then 0x8000 (wrap) / 0x7FFF (SAT_EN); a following VRED with LANES=4 gives lane 0 = 4*0x8000 truncated to 0x0000 (wrap) / 0x7FFF (SAT_EN).
REQ-027 SHALL cover backpressure: hold out_ready=0 for 5 cycles during a stream of 6 ops -> in_ready=0 during the hold, out_data stable, all 6 results delivered in order.
REQ-028 SHALL cover flush with VMAC in E1 and E2 -> neither result appears, a following VRED equals the pre-flush accumulator sum, and the E3 op completes.
REQ-029 SHALL cover reset asserted with 3 ops in flight -> next cycle out_valid=0, busy=0; a following VRED returns 0.
